// File: rtl/up_down_counter_pkg.sv
// rtl/up_down_counter_pkg.sv - shared direction encodings for up_down_counter
package up_down_counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage : up_down_counter_pkg

// File: rtl/up_down_counter.sv
// rtl/up_down_counter.sv - saturating up/down counter with limit-reached flag
module up_down_counter
    import up_down_counter_pkg::*;
#(
    parameter int INPUT_BIT_WIDTH = 8
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       UpDownMode,
    output logic [INPUT_BIT_WIDTH-1:0] Output,
    output logic                       LimitReachedFlag
);

    localparam logic [INPUT_BIT_WIDTH-1:0] MAX  = '1;
    localparam logic [INPUT_BIT_WIDTH-1:0] ZERO = '0;
    localparam logic [INPUT_BIT_WIDTH-1:0] ONE  = INPUT_BIT_WIDTH'(1);

    logic [INPUT_BIT_WIDTH-1:0] count_q;
    logic [INPUT_BIT_WIDTH-1:0] count_d;

    // Bound is checked before stepping so the count never wraps.
    function automatic logic [INPUT_BIT_WIDTH-1:0] sat_next(
        input logic [INPUT_BIT_WIDTH-1:0] cur,
        input logic                       up
    );
        logic [INPUT_BIT_WIDTH-1:0] nxt;
        nxt = cur;
        if (up == DIR_UP) begin
            if (cur != MAX) nxt = cur + ONE;
        end else begin
            if (cur != ZERO) nxt = cur - ONE;
        end
        return nxt;
    endfunction

    always_comb begin
        count_d = sat_next(count_q, UpDownMode);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            count_q <= ZERO;
        end else begin
            count_q <= count_d;
        end
    end

    assign Output           = count_q;
    assign LimitReachedFlag = (UpDownMode == DIR_UP) ? (count_q == MAX) : (count_q == ZERO);

endmodule : up_down_counter

// File: tb/tb_up_down_counter.sv
// tb/tb_up_down_counter.sv - directed self-checking bench for up_down_counter
module tb_up_down_counter;

    logic       clk;
    logic       rst;
    logic       mode;
    logic [7:0] out8;
    logic       flag8;

    logic       rst1;
    logic       mode1;
    logic [0:0] out1;
    logic       flag1;

    int vectors;
    int miscompares;

    up_down_counter #(.INPUT_BIT_WIDTH(8)) dut8 (
        .Clk              (clk),
        .Reset            (rst),
        .UpDownMode       (mode),
        .Output           (out8),
        .LimitReachedFlag (flag8)
    );

    up_down_counter #(.INPUT_BIT_WIDTH(1)) dut1 (
        .Clk              (clk),
        .Reset            (rst1),
        .UpDownMode       (mode1),
        .Output           (out1),
        .LimitReachedFlag (flag1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges and settle 1ns past the last one.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
        end
        #1;
    endtask

    task automatic chk8(input string name, input logic [7:0] exp_out, input logic exp_flag);
        vectors++;
        if (out8 !== exp_out || flag8 !== exp_flag) begin
            miscompares++;
            $display("FAIL %s: got out=%0d flag=%0b, expected out=%0d flag=%0b",
                     name, out8, flag8, exp_out, exp_flag);
        end
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        mode = 1'b1;
        #1;
        chk8("reset_up_flag", 8'd0, 1'b0);
        mode = 1'b0;
        #1;
        chk8("reset_down_flag", 8'd0, 1'b1);
        step(2);
        chk8("reset_held_over_edges", 8'd0, 1'b1);
        rst  = 1'b0;
        mode = 1'b1;
        #1;
    endtask

    task automatic test_count_up();
        step(5);
        chk8("up_5", 8'd5, 1'b0);
    endtask

    task automatic test_count_down();
        mode = 1'b0;
        step(3);
        chk8("down_3", 8'd2, 1'b0);
        step(10);
        chk8("down_to_zero", 8'd0, 1'b1);
        step(10);
        chk8("down_hold_zero", 8'd0, 1'b1);
    endtask

    task automatic test_saturate_up();
        mode = 1'b1;
        step(127);
        chk8("up_127", 8'd127, 1'b0);
        step(256);
        chk8("up_saturate", 8'd255, 1'b1);
    endtask

    task automatic test_reverse();
        mode = 1'b0;
        #1;
        chk8("reverse_flag_drop", 8'd255, 1'b0);
        step(1);
        chk8("reverse_one_edge", 8'd254, 1'b0);
        mode = 1'b1;
        step(1);
        chk8("back_to_max", 8'd255, 1'b1);
    endtask

    task automatic test_async_reset();
        rst = 1'b1;
        #1;
        chk8("async_clear_before_edge", 8'd0, 1'b0);
        #1;
        rst = 1'b0;
        step(1);
        chk8("resume_after_release", 8'd1, 1'b0);
        step(2);
        chk8("resume_continue", 8'd3, 1'b0);
    endtask

    task automatic test_width1();
        logic [0:0] exp_o [6];
        logic       exp_f [6];
        logic       dir   [6];
        exp_o = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        exp_f = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        dir   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        rst1  = 1'b0;
        for (int k = 0; k < 6; k++) begin
            mode1 = dir[k];
            if (k == 0 || k == 3) begin
                #1;
            end else begin
                step(1);
            end
            vectors++;
            if (out1 !== exp_o[k] || flag1 !== exp_f[k]) begin
                miscompares++;
                $display("FAIL w1_step%0d: got out=%0b flag=%0b, expected out=%0b flag=%0b",
                         k, out1, flag1, exp_o[k], exp_f[k]);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst1        = 1'b1;
        mode1       = 1'b1;
        test_reset();
        test_count_up();
        test_count_down();
        test_saturate_up();
        test_reverse();
        test_async_reset();
        test_width1();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_up_down_counter
